// File: rtl/time_pkg.sv
// Shared constants for the time-of-day path: ASCII codes, parser states and
// hour/minute widths used by both the UART parser and the time counter.
package time_pkg;

  localparam logic [7:0] CHAR_T     = 8'h54;
  localparam logic [7:0] CHAR_COLON = 8'h3A;
  localparam logic [7:0] CHAR_CR    = 8'h0D;
  localparam logic [7:0] CHAR_LF    = 8'h0A;
  localparam logic [7:0] CHAR_0     = 8'h30;

  localparam int HOUR_W   = 5;
  localparam int MIN_W    = 6;
  localparam int HOUR_MAX = 23;
  localparam int MIN_MAX  = 59;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    H_TENS  = 3'd1,
    H_UNITS = 3'd2,
    COLON   = 3'd3,
    M_TENS  = 3'd4,
    M_UNITS = 3'd5,
    TERM    = 3'd6
  } parse_state_t;

  // True when b is an ASCII digit in '0'..('0'+max_d).
  function automatic logic is_digit(input logic [7:0] b, input logic [3:0] max_d);
    return (b >= CHAR_0) && (b <= (CHAR_0 + {4'b0000, max_d}));
  endfunction

endpackage

// File: rtl/byte_timeout.sv
// Inter-byte watchdog: counts idle cycles while enabled and emits a one-cycle
// expired pulse when TIMEOUT_CYCLES consecutive idle cycles have elapsed.
module byte_timeout #(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int CNT_W          = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [CNT_W-1:0] cnt;

  // clear has priority so a byte arriving on the last idle cycle wins
  assign expired = enable && !clear && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clear || expired) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_time_parser.sv
// Parses ASCII "T HH:MM <CR|LF>" frames from the UART byte stream into a
// binary hour/minute pair with a load strobe; bad or stalled frames pulse frame_error.
module uart_time_parser
  import time_pkg::*;
#(
  parameter logic [7:0] START_CHAR     = 8'h54,
  parameter int         TIMEOUT_CYCLES = 50000,
  parameter int         CNT_W          = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [HOUR_W-1:0] timp_ore2,
  output logic [MIN_W-1:0]  timp_minute2,
  output logic              load_2,
  output logic              frame_error,
  output logic              busy
);

  parse_state_t      state, state_nx;
  logic [HOUR_W-1:0] hour_acc, hour_acc_nx, hour_nx, hour_cand;
  logic [MIN_W-1:0]  min_acc, min_acc_nx, min_nx, min_cand;
  logic              load_nx, err_nx, bad_byte;
  logic [3:0]        digit;
  logic              expired;

  function automatic logic [HOUR_W-1:0] mul10_hour(input logic [HOUR_W-1:0] x);
    return (x << 3) + (x << 1);
  endfunction

  function automatic logic [MIN_W-1:0] mul10_min(input logic [MIN_W-1:0] x);
    return (x << 3) + (x << 1);
  endfunction

  byte_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CNT_W         (CNT_W)
  ) u_timeout (
    .clock  (clock),
    .reset  (reset),
    .clear  (rx_valid || (state == IDLE)),
    .enable (state != IDLE),
    .expired(expired)
  );

  // Tens digits are range-checked first, so these sums never exceed 29 / 59.
  assign digit     = 4'(rx_data - CHAR_0);
  assign hour_cand = mul10_hour(hour_acc) + HOUR_W'(digit);
  assign min_cand  = mul10_min(min_acc) + MIN_W'(digit);

  always_comb begin
    state_nx    = state;
    hour_acc_nx = hour_acc;
    min_acc_nx  = min_acc;
    hour_nx     = timp_ore2;
    min_nx      = timp_minute2;
    load_nx     = 1'b0;
    err_nx      = 1'b0;
    bad_byte    = 1'b0;

    if (rx_valid) begin
      case (state)
        IDLE: begin
          if (rx_data == START_CHAR) begin
            state_nx    = H_TENS;
            hour_acc_nx = '0;
            min_acc_nx  = '0;
          end
        end
        H_TENS: begin
          if (is_digit(rx_data, 4'd2)) begin
            hour_acc_nx = HOUR_W'(digit);
            state_nx    = H_UNITS;
          end else begin
            bad_byte = 1'b1;
          end
        end
        H_UNITS: begin
          if (is_digit(rx_data, 4'd9) && (hour_cand <= HOUR_W'(HOUR_MAX))) begin
            hour_acc_nx = hour_cand;
            state_nx    = COLON;
          end else begin
            bad_byte = 1'b1;
          end
        end
        COLON: begin
          if (rx_data == CHAR_COLON) state_nx = M_TENS;
          else                       bad_byte = 1'b1;
        end
        M_TENS: begin
          if (is_digit(rx_data, 4'd5)) begin
            min_acc_nx = MIN_W'(digit);
            state_nx   = M_UNITS;
          end else begin
            bad_byte = 1'b1;
          end
        end
        M_UNITS: begin
          if (is_digit(rx_data, 4'd9)) begin
            min_acc_nx = min_cand;
            state_nx   = TERM;
          end else begin
            bad_byte = 1'b1;
          end
        end
        TERM: begin
          if ((rx_data == CHAR_CR) || (rx_data == CHAR_LF)) begin
            hour_nx  = hour_acc;
            min_nx   = min_acc;
            load_nx  = 1'b1;
            state_nx = IDLE;
          end else begin
            bad_byte = 1'b1;
          end
        end
        default: state_nx = IDLE;
      endcase
    end

    // A stray start byte aborts the current frame but immediately opens a new one.
    if (bad_byte) begin
      err_nx   = 1'b1;
      state_nx = (rx_data == START_CHAR) ? H_TENS : IDLE;
    end else if (!rx_valid && expired) begin
      err_nx   = 1'b1;
      state_nx = IDLE;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state        <= IDLE;
      hour_acc     <= '0;
      min_acc      <= '0;
      timp_ore2    <= '0;
      timp_minute2 <= '0;
      load_2       <= 1'b0;
      frame_error  <= 1'b0;
    end else begin
      state        <= state_nx;
      hour_acc     <= hour_acc_nx;
      min_acc      <= min_acc_nx;
      timp_ore2    <= hour_nx;
      timp_minute2 <= min_nx;
      load_2       <= load_nx;
      frame_error  <= err_nx;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: doc/uart_time_parser.md
Name: uart_time_parser

Overview:
Upstream stage of the time-of-day counter. Consumes the byte stream from the UART receiver and parses ASCII time-set frames of the form 'T' H H ':' M M <CR|LF>. On a valid frame it drives a binary hour/minute pair plus a one-cycle load strobe, which the counter consumes as its UART-set inputs. Malformed or stalled frames are discarded and flagged.

Parameters:
START_CHAR, 8'h54 ('T'), frame start byte
TIMEOUT_CYCLES, 50000, maximum idle clocks between bytes inside a frame before the frame is aborted
CNT_W, 16, width of the inter-byte timeout counter; must hold TIMEOUT_CYCLES

Ports:
clock  in  1  system clock; all logic on its rising edge
reset  in  1  synchronous, active-low reset (0 = reset), sampled on the clock rising edge
rx_data  in  8  received byte from the UART RX; valid only when rx_valid=1
rx_valid  in  1  one-cycle strobe, one byte per strobe; back-to-back strobes are legal
timp_ore2  out  5  parsed hour, 0..23
timp_minute2  out  6  parsed minute, 0..59
load_2  out  1  one-cycle pulse: timp_ore2/timp_minute2 hold a new valid time
frame_error  out  1  one-cycle pulse: frame aborted (bad byte, range violation or timeout)
busy  out  1  1 while a frame is in progress (state != IDLE)

Behaviour:
- Reset (reset=0 at a rising edge): state=IDLE, timp_ore2=0, timp_minute2=0, load_2=0, frame_error=0, busy=0, digit accumulators=0, timeout counter=0.
- FSM states: IDLE, H_TENS, H_UNITS, COLON, M_TENS, M_UNITS, TERM. Transitions occur only on cycles with rx_valid=1, except for the timeout abort.
- IDLE: byte==START_CHAR -> H_TENS; any other byte is ignored silently (no error).
- H_TENS: accept '0'..'2' and store digit -> H_UNITS.
- H_UNITS: accept '0'..'9'; the combined hour must be <=23 (tens=2 requires units '0'..'3') -> COLON.
- COLON: accept ':' (8'h3A) -> M_TENS.
- M_TENS: accept '0'..'5' -> M_UNITS.
- M_UNITS: accept '0'..'9' -> TERM.
- TERM: accept CR (8'h0D) or LF (8'h0A). On acceptance, the registers take hour = tens*10+units (5-bit) and minute = tens*10+units (6-bit). load_2=1 in the cycle after the terminator strobe (1-cycle latency). Next state: IDLE.
- Any non-accepted byte in H_TENS..TERM: frame_error=1 for exactly one cycle (the cycle after the strobe), outputs unchanged, no load_2. Exception: if the bad byte == START_CHAR, the frame restarts (-> H_TENS) with frame_error still pulsed. Otherwise -> IDLE.
- Timeout: the counter clears on every rx_valid and in IDLE, and increments each cycle in non-IDLE states without rx_valid. On reaching TIMEOUT_CYCLES: frame_error pulse, -> IDLE, counter cleared.
- Simultaneous timeout and rx_valid in the same cycle: the byte wins and the counter clears.
- timp_ore2/timp_minute2 change only on a completed valid frame and hold their value otherwise. load_2 and frame_error are never asserted together.
- Reset mid-frame: the partial frame is discarded, outputs return to 0, and no pulses are generated.
- Arithmetic: multiply by 10 is implemented as (x<<3)+(x<<1) at accumulator width. No wrap is possible, because the digits are range-checked before the multiply.

Decomposition:
- Shared package/header time_pkg: ASCII constants (CHAR_T, CHAR_COLON, CHAR_CR, CHAR_LF, CHAR_0), FSM state encoding localparams, HOUR_MAX=23, MIN_MAX=59, widths HOUR_W=5 and MIN_W=6 (shared with the time counter).
- One sub-module: byte_timeout, the inter-byte watchdog counter. Inputs: clear, enable. Output: one-cycle expired pulse. Parameterised by TIMEOUT_CYCLES and CNT_W.

Test Plan:
- Send "T12:34\r" back-to-back -> one cycle after the CR strobe: load_2=1 for 1 cycle, timp_ore2=12, timp_minute2=34, frame_error never 1.
- Send "T24:00\n" -> frame_error pulse after the '4' byte, no load_2, outputs keep their previous values. Then send "T23:59\n" -> load_2, 23/59.
- Send "T0" then "T07:05\r" (restart mid-frame) -> frame_error pulse on the second 'T', then load_2 with 7/5.
- Send "T1" then idle TIMEOUT_CYCLES (use 20 in the bench) -> frame_error at cycle 20, busy drops to 0. A subsequent "T00:00\n" loads 0/0.
- Send "T09:6" -> frame_error after '6' (minute tens > 5). Then send garbage bytes "xyz" in IDLE -> no error pulses.
- Assert reset=0 for one cycle after "T11:1" -> outputs 0, busy=0. A subsequent "5\r" is ignored (no load_2, no error).
